// File: rtl/psum_accumulator.sv
// Accumulates NUM_TILES signed partial sums from a PE into one saturated
// output activation, handed off over a valid/ready handshake.
module psum_accumulator #(
    parameter int IN_BITWIDTH  = 16,
    parameter int ACC_BITWIDTH = 24,
    parameter int NUM_TILES    = 4
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [IN_BITWIDTH-1:0]           in_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [ACC_BITWIDTH-1:0]          out_data,
    output logic                             out_saturated,
    output logic [$clog2(NUM_TILES+1)-1:0]   tile_count
);

    localparam int CW = $clog2(NUM_TILES + 1);
    localparam int AW = ACC_BITWIDTH;

    localparam logic [AW-1:0] ACC_MAX = {1'b0, {(AW-1){1'b1}}};
    localparam logic [AW-1:0] ACC_MIN = {1'b1, {(AW-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t          state;
    logic [AW-1:0]   acc;
    logic            sat;
    logic [CW-1:0]   count;

    logic [AW-1:0]   ext;
    logic [AW:0]     sum;
    logic            clamp;
    logic [AW-1:0]   sum_sat;

    assign ext = AW'($signed(in_data));
    assign sum = {acc[AW-1], acc} + {ext[AW-1], ext};

    // One extra bit exposes overflow: top two bits disagree.
    assign clamp   = sum[AW] ^ sum[AW-1];
    assign sum_sat = clamp ? (sum[AW] ? ACC_MIN : ACC_MAX) : sum[AW-1:0];

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            acc   <= '0;
            sat   <= 1'b0;
            count <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        acc   <= ext;
                        sat   <= 1'b0;
                        count <= CW'(1);
                        state <= (NUM_TILES == 1) ? HOLD : ACCUM;
                    end
                end
                ACCUM: begin
                    if (in_valid) begin
                        acc   <= sum_sat;
                        sat   <= sat | clamp;
                        count <= count + CW'(1);
                        if (count == CW'(NUM_TILES - 1)) begin
                            state <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state <= IDLE;
                        acc   <= '0;
                        count <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready      = (state != HOLD);
    assign out_valid     = (state == HOLD);
    assign out_data      = acc;
    assign out_saturated = sat;
    assign tile_count    = count;

endmodule
